// File: rtl/tbox_arbiter.sv
// tbox_arbiter
//
// Round-robin arbiter sharing one synchronous-read 256x32 inverse T-box ROM
// (Td1, one-cycle read latency) between NREQ AES decryption column lanes.
// Each cycle at most one pending lookup is granted. Its address is driven to
// the ROM, and the returned word is steered back to the granted lane with a
// one-hot response strobe.
//
// Optional feature macro: TBOX_ARB_OUTREG_EN
//   undefined : rsp_data comes straight from rom_q, gated by the stage-1 id
//               (grant-to-response latency 1 cycle).
//   defined   : a second tracker stage registers rsp_valid/rsp_data
//               (latency 2 cycles, throughput unchanged).
//
// Handshake: lane i presents req_valid[i] with a stable req_addr slice. The
// lookup is accepted in the cycle where req_valid[i] && req_ready[i]; the
// lane may drop or re-assert req_valid in the very next cycle. There is no
// backpressure on the response side: rsp_valid is a single-cycle strobe.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   synchronous active-high reset
//   req_valid  in   [NREQ]    per-lane lookup request
//   req_addr   in   [8*NREQ]  lane i address in bits [8i+7:8i]
//   req_ready  out  [NREQ]    one-hot combinational grant
//   rom_a      out  [8]       ROM address (holds last granted address)
//   rom_q      in   [32]      ROM data, valid one cycle after rom_a sampled
//   rsp_valid  out  [NREQ]    one-hot response strobe
//   rsp_data   out  [32]      ROM word for the lane flagged in rsp_valid
//   busy       out  1         a lookup is in flight
module tbox_arbiter #(
    parameter int NREQ = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_addr,
    output logic [NREQ-1:0]   req_ready,
    output logic [7:0]        rom_a,
    input  logic [31:0]       rom_q,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [31:0]       rsp_data,
    output logic              busy
);

    localparam int PW = $clog2(NREQ);

    logic [PW-1:0]   ptr;
    logic [PW-1:0]   ptr_next;
    logic [PW-1:0]   win_idx;
    logic [PW-1:0]   scan_idx;
    logic [PW:0]     scan_sum;
    logic            win_found;
    logic [NREQ-1:0] grant;
    logic [7:0]      win_addr;
    logic [7:0]      rom_a_q;

    // Stage-1 tracker: one entry describing the lookup whose ROM word
    // appears on rom_q this cycle.
    logic            s1_valid;
    logic [NREQ-1:0] s1_id;

    // Scan lanes starting at ptr, ascending with explicit wrap so that a
    // non-power-of-two NREQ never visits an index >= NREQ.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        grant     = '0;
        win_addr  = '0;
        scan_sum  = '0;
        scan_idx  = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan_sum = {1'b0, ptr} + (PW+1)'(k);
            if (scan_sum >= (PW+1)'(NREQ)) begin
                scan_sum = scan_sum - (PW+1)'(NREQ);
            end
            scan_idx = scan_sum[PW-1:0];
            if (!win_found && req_valid[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
        end
        if (reset) begin
            win_found = 1'b0;
        end
        if (win_found) begin
            grant[win_idx] = 1'b1;
            win_addr       = req_addr[{win_idx, 3'b000} +: 8];
        end
    end

    always_comb begin
        if (win_idx == PW'(NREQ - 1)) begin
            ptr_next = '0;
        end else begin
            ptr_next = win_idx + 1'b1;
        end
    end

    assign req_ready = grant;
    // Without a winner the ROM address is held to avoid spurious toggling.
    assign rom_a     = win_found ? win_addr : rom_a_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr      <= '0;
            rom_a_q  <= '0;
            s1_valid <= 1'b0;
            s1_id    <= '0;
        end else begin
            if (win_found) begin
                ptr     <= ptr_next;
                rom_a_q <= win_addr;
            end
            s1_valid <= win_found;
            s1_id    <= grant;
        end
    end

`ifdef TBOX_ARB_OUTREG_EN
    logic            s2_valid;
    logic [NREQ-1:0] out_valid;
    logic [31:0]     out_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            s2_valid  <= 1'b0;
            out_valid <= '0;
            out_data  <= '0;
        end else begin
            s2_valid  <= s1_valid;
            out_valid <= s1_valid ? s1_id : '0;
            if (s1_valid) begin
                out_data <= rom_q;
            end
        end
    end

    // A lookup still in the output stage while reset is high is discarded.
    assign rsp_valid = reset ? '0 : out_valid;
    assign rsp_data  = out_data;
    assign busy      = !reset && (s1_valid || s2_valid);
`else
    logic        deliver;
    logic [31:0] hold_data;

    // Reset in the response cycle drops the in-flight lookup.
    assign deliver   = s1_valid && !reset;
    assign rsp_valid = deliver ? s1_id : '0;
    assign rsp_data  = deliver ? rom_q : hold_data;

    // Remembers the last delivered word so rsp_data holds between strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_data <= '0;
        end else if (deliver) begin
            hold_data <= rom_q;
        end
    end

    assign busy = deliver;
`endif

endmodule

// File: tb/tb_tbox_arbiter.sv
// tb_tbox_arbiter
//
// Bench for tbox_arbiter (NREQ = 4). Provides a synchronous-read Td1 ROM
// holding the entries the directed vectors use, a cycle-level reference
// model compared against every output on every cycle, and directed vectors
// with hand-computed literal expectations.
module tb_tbox_arbiter;

    localparam int NREQ = 4;
`ifdef TBOX_ARB_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    // clock / reset
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_addr;
    logic [NREQ-1:0]   req_ready;
    logic [7:0]        rom_a;
    logic [31:0]       rom_q;
    logic [NREQ-1:0]   rsp_valid;
    logic [31:0]       rsp_data;
    logic              busy;

    tbox_arbiter #(.NREQ(NREQ)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_ready (req_ready),
        .rom_a     (rom_a),
        .rom_q     (rom_q),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .busy      (busy)
    );

    // Td1 contents for the addresses exercised; other entries get a
    // distinctive filler pattern.
    function automatic logic [31:0] td1(input logic [7:0] a);
        case (a)
            8'd0:    return 32'h5051f4a7;
            8'd1:    return 32'h537e4165;
            8'd2:    return 32'hc31a17a4;
            8'd99:   return 32'h00000000;
            8'd255:  return 32'h42d0b857;
            default: return {a, a ^ 8'h1b, 8'hc3, ~a};
        endcase
    endfunction

    always @(posedge clk) rom_q <= td1(rom_a);

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model
    typedef struct {
        int          lane;
        logic [31:0] data;
        int          gcyc;
        int          due;
    } pend_t;

    pend_t           exp_q[$];
    bit              check_en = 1'b0;
    int              cyc = 0;
    int              m_ptr = 0;
    int              m_win;
    logic [7:0]      m_rom_a = 8'h0;
    logic [31:0]     m_rsp_data = 32'h0;
    logic [NREQ-1:0] e_ready;
    logic [7:0]      e_rom_a;
    logic [NREQ-1:0] e_rsp_valid;
    logic [31:0]     e_rsp_data;
    logic            e_busy;

    always @(negedge clk) begin
        if (check_en) begin
            m_win   = -1;
            e_ready = '0;
            e_rom_a = m_rom_a;
            if (!reset) begin
                for (int k = 0; k < NREQ; k++) begin
                    if (m_win < 0 && req_valid[(m_ptr + k) % NREQ]) m_win = (m_ptr + k) % NREQ;
                end
            end
            if (m_win >= 0) begin
                e_ready[m_win] = 1'b1;
                e_rom_a = 8'(req_addr >> (8 * m_win));
            end
            e_rsp_valid = '0;
            e_rsp_data  = m_rsp_data;
            e_busy      = 1'b0;
            if (!reset) begin
                foreach (exp_q[j]) begin
                    if (exp_q[j].due == cyc) begin
                        e_rsp_valid[exp_q[j].lane] = 1'b1;
                        e_rsp_data = exp_q[j].data;
                    end
                    if (exp_q[j].gcyc < cyc) e_busy = 1'b1;
                end
            end
            chk("model_req_ready", 32'(req_ready), 32'(e_ready));
            chk("model_rom_a", 32'(rom_a), 32'(e_rom_a));
            chk("model_rsp_valid", 32'(rsp_valid), 32'(e_rsp_valid));
            chk("model_rsp_data", rsp_data, e_rsp_data);
            chk("model_busy", 32'(busy), 32'(e_busy));
            if (reset) begin
                exp_q.delete();
                m_ptr      = 0;
                m_rom_a    = 8'h0;
                m_rsp_data = 32'h0;
            end else begin
                m_rsp_data = e_rsp_data;
                while (exp_q.size() > 0 && exp_q[0].due <= cyc) void'(exp_q.pop_front());
                if (m_win >= 0) begin
                    exp_q.push_back('{lane: m_win, data: td1(e_rom_a), gcyc: cyc, due: cyc + LAT});
                    m_ptr   = (m_win + 1) % NREQ;
                    m_rom_a = e_rom_a;
                end
            end
            cyc++;
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    logic [NREQ-1:0] gseq[4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [31:0]     dseq[4] = '{32'h00000000, 32'h42d0b857, 32'hc31a17a4, 32'h537e4165};

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        req_addr  = '0;
        @(posedge clk);
        #1;
        check_en = 1'b1;
        tick();

        // reset state
        sample();
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_rom_a", 32'(rom_a), 32'h0);
        chk("rst_rsp_data", rsp_data, 32'h0);
        tick();
        reset = 1'b0;
        tick();

        // single lookup: lane 0, addr 0
        req_valid = 4'b0001;
        req_addr  = {8'd0, 8'd0, 8'd0, 8'd0};
        sample();
        chk("single_ready", 32'(req_ready), 32'h1);
        chk("single_rom_a", 32'(rom_a), 32'h0);
        tick();
        req_valid = '0;
        repeat (LAT - 1) tick();
        sample();
        chk("single_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("single_rsp_data", rsp_data, 32'h5051f4a7);
        tick();

        // all lanes continuously requesting; pointer sits at lane 1
        req_addr = {8'd2, 8'd255, 8'd99, 8'd1};
        for (int i = 0; i < 8 + LAT; i++) begin
            req_valid = (i < 8) ? 4'b1111 : 4'b0000;
            sample();
            chk("rr_ready", 32'(req_ready), (i < 8) ? 32'(gseq[i % 4]) : 32'h0);
            if (i >= LAT) begin
                chk("rr_rsp_valid", 32'(rsp_valid), 32'(gseq[(i - LAT) % 4]));
                chk("rr_rsp_data", rsp_data, dseq[(i - LAT) % 4]);
            end
            tick();
        end

        // pointer fairness: grant lane 2, then lanes 1 and 3 together
        req_addr  = {8'd3, 8'd5, 8'd7, 8'd9};
        req_valid = 4'b0100;
        sample();
        chk("fair_lane2", 32'(req_ready), 32'h4);
        tick();
        req_valid = 4'b1010;
        sample();
        chk("fair_first_lane3", 32'(req_ready), 32'h8);
        tick();
        req_valid = 4'b0010;
        sample();
        chk("fair_then_lane1", 32'(req_ready), 32'h2);
        tick();
        req_valid = '0;
        repeat (LAT + 1) tick();

        // back-to-back: lane 1 re-requests addr 255 in its response cycle
        req_addr = {8'd0, 8'd0, 8'd255, 8'd0};
        for (int j = 0; j <= LAT; j++) begin
            req_valid = 4'b0010;
            sample();
            chk("b2b_ready", 32'(req_ready), 32'h2);
            if (j == LAT) begin
                chk("b2b_rsp_valid", 32'(rsp_valid), 32'h2);
                chk("b2b_rsp_data", rsp_data, 32'h42d0b857);
            end
            tick();
        end
        req_valid = '0;
        repeat (LAT - 1) tick();
        sample();
        chk("b2b_rsp2_valid", 32'(rsp_valid), 32'h2);
        chk("b2b_rsp2_data", rsp_data, 32'h42d0b857);
        tick();

        // idle: outputs hold
        for (int i = 0; i < 10; i++) begin
            sample();
            chk("idle_ready", 32'(req_ready), 32'h0);
            chk("idle_rsp_valid", 32'(rsp_valid), 32'h0);
            chk("idle_rom_a", 32'(rom_a), 32'hff);
            chk("idle_rsp_data", rsp_data, 32'h42d0b857);
            tick();
        end

        // reset with a lookup in flight
        req_addr  = {8'd2, 8'd255, 8'd99, 8'd1};
        req_valid = 4'b0001;
        sample();
        chk("rstflt_grant", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        reset     = 1'b1;
        sample();
        chk("rstflt_no_rsp0", 32'(rsp_valid), 32'h0);
        tick();
        sample();
        chk("rstflt_no_rsp1", 32'(rsp_valid), 32'h0);
        tick();
        reset = 1'b0;
        sample();
        chk("rstflt_busy", 32'(busy), 32'h0);
        chk("rstflt_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rstflt_rom_a", 32'(rom_a), 32'h0);
        chk("rstflt_rsp_data", rsp_data, 32'h0);
        chk("rstflt_ready", 32'(req_ready), 32'h0);
        tick();
        req_valid = 4'b1111;
        sample();
        chk("rstflt_first_lane0", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        repeat (LAT + 2) tick();

        // final report
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tbox_arbiter.md
# tbox_arbiter

Round-robin arbiter that shares one synchronous-read 256x32 inverse T-box ROM (Td1, 1-cycle read latency) between `NREQ` AES decryption column lanes. Each cycle it grants at most one pending lookup, drives the ROM address, and returns the 32-bit ROM word to the granted lane with a per-lane valid strobe. It sits between the decryption round datapath and the T-box ROM instance inside the AES accelerator.

## Interface
- `NREQ`, 4: number of requesting lanes (2..8).
- `clk` in 1: system clock; all state on rising edge.
- `reset` in 1: synchronous, active-high reset.
- `req_valid` in NREQ: lane i has a pending lookup.
- `req_addr` in 8*NREQ: lane i address at bits [8i+7:8i]; stable while `req_valid[i]` is high and not yet granted.
- `req_ready` out NREQ: one-hot grant, combinational; lookup i is accepted in a cycle where `req_valid[i] && req_ready[i]`.
- `rom_a` out 8: address to ROM `a` input.
- `rom_q` in 32: ROM `q` output, valid one cycle after `rom_a` is sampled.
- `rsp_valid` out NREQ: one-hot response strobe, one cycle wide.
- `rsp_data` out 32: ROM word for lane flagged in `rsp_valid`.
- `busy` out 1: a lookup is in flight (issued, response not yet delivered).

## Operation
- Round-robin pointer `ptr` (log2 NREQ bits), reset 0. Search starts at lane `ptr`, ascending, wrapping NREQ-1 -> 0; the first lane with `req_valid` high wins.
- On a grant to lane w: `ptr` <= (w+1) mod NREQ. With no grant, `ptr` holds.
- At most one grant per cycle; `req_ready` is all-zero when no `req_valid` is high or `reset` is high.
- `rom_a` = `req_addr` of winner; with no winner, `rom_a` holds its last granted value (no spurious change; reset value 0).
- Pipeline tracker: stage-1 register {valid, one-hot id} captures the grant. The cycle after, `rsp_valid` = id if valid, `rsp_data` = `rom_q`.
- `rsp_data` holds its last value when `rsp_valid` is zero; reset value 32'h0.
- A lane may re-request in the cycle it receives its response, or back-to-back with a grant; throughput is one lookup per cycle in aggregate.
- Fairness: with all lanes continuously requesting, each lane is granted exactly once every NREQ cycles.
- `busy` = OR of all tracker stage valids.

## Timing
- Grant: same cycle as request (combinational `req_ready`).
- Latency, grant edge to `rsp_valid`: 1 cycle (2 with output register, see Configuration).
- Reset values: `ptr`=0, tracker valids=0, `rsp_valid`=0, `rsp_data`=0, `rom_a`=0, `busy`=0.
- Reset mid-operation: in-flight lookups are discarded, no `rsp_valid` is produced for them, and the first grant after reset deasserts starts from lane 0.
- Simultaneous grant and response in one cycle is normal pipelined operation; the response belongs to the previous grant.
- NREQ not a power of two: pointer wrap is explicit modulo NREQ, and pointer values >= NREQ are unreachable.

## Configuration
- `TBOX_ARB_OUTREG_EN` defined: adds a second tracker stage plus a registered `rsp_data`/`rsp_valid` output stage. Latency is 2 cycles and throughput is unchanged. `busy` covers both stages.
- Not defined: `rsp_data` is driven directly from `rom_q`, gated by the stage-1 id. Latency is 1 cycle.

## Test plan
- Single lookup: lane 0 requests addr 8'd0 -> `req_ready`=4'b0001 the same cycle. `rsp_valid`=4'b0001 with `rsp_data`=32'h5051f4a7 after 1 cycle (2 with OUTREG).
- All four lanes request continuously, addrs 1/99/255/2 -> grants cycle 0,1,2,3,0... Responses are 32'h537e4165, 32'h0, 32'h42d0b857 and 32'hc31a17a4, each tagged to the correct lane.
- Pointer fairness: after a grant to lane 2, lanes 1 and 3 request together -> lane 3 is granted first, then lane 1.
- Back-to-back: lane 1 re-requests addr 8'd255 in its response cycle -> granted with no bubble (sole requester). Response is 32'h42d0b857.
- Reset with a lookup in flight: assert `reset` the cycle after a grant -> no `rsp_valid` appears. After release, `busy`=0, all outputs are 0, and the first grant with all lanes requesting goes to lane 0.
- Idle: no `req_valid` for 10 cycles -> `req_ready`=0, `rsp_valid`=0, and `rom_a` and `rsp_data` hold their previous values.
